fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, PC loaded on reset.
REQ-002 SHALL have parameter IRQ_VEC, default 16'h0004, interrupt redirect target.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port stall  in  1  downstream not accepting instruction.
REQ-006 SHALL have port br_taken  in  1  branch redirect request.
REQ-007 SHALL have port br_target  in  16  branch target.
REQ-008 SHALL have port jmp_valid  in  1  jump redirect request.
REQ-009 SHALL have port jmp_target  in  16  jump target.
REQ-010 SHALL have port irq  in  1  level interrupt request.
REQ-011 SHALL have port irq_en  in  1  interrupt enable (level).
REQ-012 SHALL have port imem_req  out  1  fetch request.
REQ-013 SHALL have port imem_addr  out  16  fetch word address.
REQ-014 SHALL have port imem_ack  in  1  fetch data valid this cycle.
REQ-015 SHALL have port imem_rdata  in  16  fetched instruction.
REQ-016 SHALL have port instr_valid  out  1  instruction offered downstream.
REQ-017 SHALL have port instr  out  16  held instruction.
REQ-018 SHALL have port instr_pc  out  16  address of instr.
REQ-019 SHALL have port epc  out  16  return PC saved on interrupt.
REQ-020 SHALL have port irq_ack  out  1  one-cycle pulse when interrupt taken.

Function
REQ-021 SHALL keep registers pc[15:0], state {FETCH, ISSUE}, redir_pend, redir_pc[15:0], instr, instr_pc, epc.
REQ-022 SHALL define redirect = jmp_valid | br_taken; target = jmp_target if jmp_valid else br_target (jump wins).
REQ-023 SHALL in FETCH drive imem_req=1, imem_addr=pc; both held stable until imem_ack.
REQ-024 SHALL in FETCH on imem_ack with no redirect and redir_pend=0 latch instr<=imem_rdata, instr_pc<=pc, go ISSUE.
REQ-025 SHALL in FETCH on imem_ack with redirect: discard data, pc<=target, clear redir_pend, stay FETCH.
REQ-026 SHALL in FETCH on imem_ack with redir_pend=1 and no redirect: discard data, pc<=redir_pc, clear redir_pend, stay FETCH.
REQ-027 SHALL in FETCH without imem_ack on redirect: redir_pc<=target, redir_pend<=1 (newest overwrites), pc unchanged.
REQ-028 SHALL drive instr_valid = (state==ISSUE) & ~redirect & ~irq_take; imem_req=0 in ISSUE.
REQ-029 SHALL define irq_take = (state==ISSUE) & irq & irq_en & ~redirect & ~stall.
REQ-030 SHALL in ISSUE on redirect: pc<=target, go FETCH (instruction squashed regardless of stall).
REQ-031 SHALL in ISSUE on irq_take: epc<=instr_pc, pc<=IRQ_VEC, irq_ack=1 that cycle, go FETCH; instruction not consumed.
REQ-032 SHALL in ISSUE with instr_valid=1 and stall=0: pc<=instr_pc+1, go FETCH (one-cycle handoff).
REQ-033 SHALL in ISSUE with stall=1 and no redirect: hold all registers, instr_valid stays 1.
REQ-034 SHALL compute pc+1 modulo 2^16 (16'hFFFF -> 16'h0000).
REQ-035 SHALL ignore stall, irq and imem_rdata outside the conditions above.
REQ-036 SHALL give minimum issue rate of one instruction per 2 cycles with zero-wait memory.

Reset
REQ-037 SHALL on any clk edge with rst=1 set pc=RESET_PC, state=FETCH, redir_pend=0, instr=0, instr_pc=0, epc=0.
REQ-038 SHALL force imem_req=0, instr_valid=0, irq_ack=0 combinationally while rst=1.
REQ-039 SHALL abandon an outstanding fetch on reset; a later imem_ack for it is treated as ack for RESET_PC fetch only if arriving after first post-reset request.
REQ-040 SHALL give rst priority over every other input.

Verification
REQ-041 SHALL test reset release, ack every 2nd cycle, stall=0 -> imem_addr 0000,0001,0002; instr_pc matches each beat.
REQ-042 SHALL test stall=1 for 3 cycles in ISSUE -> instr_valid held, instr/instr_pc unchanged, no imem_req.
REQ-043 SHALL test jmp_valid(target 0x0100) and br_taken(0x0200) same ISSUE cycle -> instr_valid=0, next imem_addr=0x0100.
REQ-044 SHALL test br_taken(0x0040) during FETCH with ack 2 cycles later -> addr held, data discarded, next imem_addr=0x0040.
REQ-045 SHALL test irq=1, irq_en=1, instr_pc=0x0010 in ISSUE -> irq_ack pulse, epc=0x0010, next imem_addr=0x0004.
REQ-046 SHALL test pc=0xFFFF issued with stall=0 -> next imem_addr=0x0000.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: a single-entry fetch/issue loop with branch/jump
// redirect, a deferred redirect for in-flight fetches, and an interrupt vector.
module fetch_ctrl #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter logic [15:0] IRQ_VEC  = 16'h0004
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        br_taken,
   input  logic [15:0] br_target,
   input  logic        jmp_valid,
   input  logic [15:0] jmp_target,
   input  logic        irq,
   input  logic        irq_en,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic        imem_ack,
   input  logic [15:0] imem_rdata,
   output logic        instr_valid,
   output logic [15:0] instr,
   output logic [15:0] instr_pc,
   output logic [15:0] epc,
   output logic        irq_ack
);

   typedef enum logic {FETCH = 1'b0, ISSUE = 1'b1} state_t;

   state_t      state;
   logic [15:0] pc;
   logic        redir_pend;
   logic [15:0] redir_pc;

   logic        redirect;
   logic [15:0] target;
   logic        irq_take;

   // Jump wins when both redirect sources fire in the same cycle.
   assign redirect = jmp_valid | br_taken;
   assign target   = jmp_valid ? jmp_target : br_target;
   assign irq_take = (state == ISSUE) & irq & irq_en & ~redirect & ~stall;

   assign imem_req    = ~rst & (state == FETCH);
   assign imem_addr   = pc;
   assign instr_valid = ~rst & (state == ISSUE) & ~redirect & ~irq_take;
   assign irq_ack     = ~rst & irq_take;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= FETCH;
         pc         <= RESET_PC;
         redir_pend <= 1'b0;
         redir_pc   <= 16'h0000;
         instr      <= 16'h0000;
         instr_pc   <= 16'h0000;
         epc        <= 16'h0000;
      end else begin
         case (state)
            FETCH: begin
               if (imem_ack) begin
                  // Data returned for a stale address is dropped and the
                  // fetch restarts at the newest redirect target.
                  if (redirect) begin
                     pc         <= target;
                     redir_pend <= 1'b0;
                  end else if (redir_pend) begin
                     pc         <= redir_pc;
                     redir_pend <= 1'b0;
                  end else begin
                     instr    <= imem_rdata;
                     instr_pc <= pc;
                     state    <= ISSUE;
                  end
               end else if (redirect) begin
                  // Address must stay stable until ack; remember the target.
                  redir_pc   <= target;
                  redir_pend <= 1'b1;
               end
            end
            ISSUE: begin
               if (redirect) begin
                  pc    <= target;
                  state <= FETCH;
               end else if (irq_take) begin
                  epc   <= instr_pc;
                  pc    <= IRQ_VEC;
                  state <= FETCH;
               end else if (!stall) begin
                  pc    <= instr_pc + 16'h0001;
                  state <= FETCH;
               end
            end
            default: state <= FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus a randomized run against a
// transaction-level model (held-instruction queue, pending redirect).
module tb_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst, stall, br_taken, jmp_valid, irq, irq_en, imem_ack;
   logic [15:0] br_target, jmp_target, imem_rdata;
   logic        imem_req, instr_valid, irq_ack;
   logic [15:0] imem_addr, instr, instr_pc, epc;

   int n_tests = 0;
   int n_fail  = 0;

   fetch_ctrl #(.RESET_PC(16'h0000), .IRQ_VEC(16'h0004)) dut (
      .clk(clk), .rst(rst), .stall(stall),
      .br_taken(br_taken), .br_target(br_target),
      .jmp_valid(jmp_valid), .jmp_target(jmp_target),
      .irq(irq), .irq_en(irq_en),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
      .epc(epc), .irq_ack(irq_ack)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      stall = 0; br_taken = 0; jmp_valid = 0; irq = 0; irq_en = 0;
      imem_ack = 0; br_target = 0; jmp_target = 0; imem_rdata = 0;
   endtask

   task automatic test_reset();
      rst = 1; idle();
      imem_ack = 1; imem_rdata = 16'hDEAD; irq = 1; irq_en = 1;
      jmp_valid = 1; jmp_target = 16'h0055;
      tick();
      n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b exp 0", imem_req); end
      n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b exp 0", instr_valid); end
      n_tests++; if (irq_ack !== 1'b0) begin n_fail++; $display("FAIL reset_irq_ack: got %b exp 0", irq_ack); end
      tick();
      rst = 0; idle();
      #1;
      n_tests++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_fetch: req %b addr %h exp 1 0000", imem_req, imem_addr); end
      n_tests++; if (instr !== 16'h0 || instr_pc !== 16'h0 || epc !== 16'h0) begin n_fail++; $display("FAIL reset_regs: instr %h pc %h epc %h exp 0", instr, instr_pc, epc); end
   endtask

   // Ack every second cycle, no stall: addresses 0,1,2 issued in order.
   task automatic test_sequential();
      for (int k = 0; k < 3; k++) begin
         idle(); #1;
         n_tests++; if (imem_req !== 1'b1 || imem_addr !== 16'(k)) begin n_fail++; $display("FAIL seq_addr%0d: req %b addr %h exp 1 %h", k, imem_req, imem_addr, 16'(k)); end
         tick();
         imem_ack = 1; imem_rdata = 16'hA000 + 16'(k); #1;
         n_tests++; if (imem_addr !== 16'(k)) begin n_fail++; $display("FAIL seq_hold%0d: addr %h exp %h", k, imem_addr, 16'(k)); end
         tick();
         idle(); #1;
         n_tests++; if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr !== 16'hA000 + 16'(k) || instr_pc !== 16'(k))
            begin n_fail++; $display("FAIL seq_issue%0d: v %b req %b instr %h pc %h exp 1 0 %h %h", k, instr_valid, imem_req, instr, instr_pc, 16'hA000 + 16'(k), 16'(k)); end
         tick();
      end
   endtask

   task automatic test_stall();
      idle(); imem_ack = 1; imem_rdata = 16'hB003;
      tick();
      idle(); stall = 1;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_tests++; if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr !== 16'hB003 || instr_pc !== 16'h0003)
            begin n_fail++; $display("FAIL stall_hold%0d: v %b req %b instr %h pc %h exp 1 0 b003 0003", c, instr_valid, imem_req, instr, instr_pc); end
         tick();
      end
      stall = 0; #1;
      n_tests++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL stall_release: v %b exp 1", instr_valid); end
      tick(); #1;
      n_tests++; if (imem_req !== 1'b1 || imem_addr !== 16'h0004) begin n_fail++; $display("FAIL stall_next: req %b addr %h exp 1 0004", imem_req, imem_addr); end
   endtask

   task automatic test_jmp_br();
      idle(); imem_ack = 1; imem_rdata = 16'hC004;
      tick();
      idle(); jmp_valid = 1; jmp_target = 16'h0100; br_taken = 1; br_target = 16'h0200; #1;
      n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL jmpbr_squash: v %b exp 0", instr_valid); end
      tick();
      idle(); #1;
      n_tests++; if (imem_req !== 1'b1 || imem_addr !== 16'h0100) begin n_fail++; $display("FAIL jmpbr_target: req %b addr %h exp 1 0100", imem_req, imem_addr); end
   endtask

   task automatic test_fetch_redirect();
      idle(); br_taken = 1; br_target = 16'h0040; #1;
      n_tests++; if (imem_addr !== 16'h0100) begin n_fail++; $display("FAIL fredir_addr0: addr %h exp 0100", imem_addr); end
      tick();
      idle(); #1;
      n_tests++; if (imem_req !== 1'b1 || imem_addr !== 16'h0100) begin n_fail++; $display("FAIL fredir_addr1: req %b addr %h exp 1 0100", imem_req, imem_addr); end
      tick();
      imem_ack = 1; imem_rdata = 16'hBAD0; #1;
      n_tests++; if (imem_addr !== 16'h0100) begin n_fail++; $display("FAIL fredir_addr2: addr %h exp 0100", imem_addr); end
      tick();
      idle(); #1;
      n_tests++; if (imem_req !== 1'b1 || imem_addr !== 16'h0040 || instr_valid !== 1'b0)
         begin n_fail++; $display("FAIL fredir_next: req %b addr %h v %b exp 1 0040 0", imem_req, imem_addr, instr_valid); end
   endtask

   task automatic test_irq();
      idle(); imem_ack = 1; jmp_valid = 1; jmp_target = 16'h0010;
      tick();
      idle(); imem_ack = 1; imem_rdata = 16'hC010;
      tick();
      idle(); irq = 1; irq_en = 1; #1;
      n_tests++; if (irq_ack !== 1'b1 || instr_valid !== 1'b0 || instr_pc !== 16'h0010)
         begin n_fail++; $display("FAIL irq_take: ack %b v %b pc %h exp 1 0 0010", irq_ack, instr_valid, instr_pc); end
      tick();
      idle(); #1;
      n_tests++; if (epc !== 16'h0010 || imem_addr !== 16'h0004 || imem_req !== 1'b1 || irq_ack !== 1'b0)
         begin n_fail++; $display("FAIL irq_vector: epc %h addr %h req %b ack %b exp 0010 0004 1 0", epc, imem_addr, imem_req, irq_ack); end
   endtask

   task automatic test_wrap();
      idle(); imem_ack = 1; jmp_valid = 1; jmp_target = 16'hFFFF;
      tick();
      idle(); imem_ack = 1; imem_rdata = 16'h7777;
      tick();
      idle(); #1;
      n_tests++; if (instr_valid !== 1'b1 || instr_pc !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_issue: v %b pc %h exp 1 ffff", instr_valid, instr_pc); end
      tick(); #1;
      n_tests++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin n_fail++; $display("FAIL wrap_next: req %b addr %h exp 1 0000", imem_req, imem_addr); end
   endtask

   // Model: a queue holds at most one fetched {pc,instr}; empty queue = fetching.
   task automatic test_random();
      logic [31:0] held[$];
      logic [15:0] m_pc, m_epc, m_rpc, tgt, m_instr, m_ipc;
      logic        m_pend, redir, fetching, irqt;
      logic        e_req, e_valid, e_ack;
      m_pc = 0; m_epc = 0; m_rpc = 0; m_pend = 0; m_instr = 0; m_ipc = 0;
      rst = 1; idle(); tick(); rst = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         rst        = ($urandom_range(0, 49) == 0);
         stall      = ($urandom_range(0, 2) == 0);
         br_taken   = ($urandom_range(0, 7) == 0);
         jmp_valid  = ($urandom_range(0, 9) == 0);
         br_target  = 16'($urandom);
         jmp_target = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
         irq        = ($urandom_range(0, 4) == 0);
         irq_en     = ($urandom_range(0, 1) == 0);
         imem_ack   = ($urandom_range(0, 1) == 0);
         imem_rdata = 16'($urandom);
         #1;
         redir    = jmp_valid | br_taken;
         tgt      = jmp_valid ? jmp_target : br_target;
         fetching = (held.size() == 0);
         irqt     = !fetching && irq && irq_en && !redir && !stall;
         e_req    = !rst && fetching;
         e_valid  = !rst && !fetching && !redir && !irqt;
         e_ack    = !rst && irqt;
         n_tests++; if (imem_req !== e_req || imem_addr !== m_pc)
            begin n_fail++; $display("FAIL rand_fetch@%0d: req %b addr %h exp %b %h", cyc, imem_req, imem_addr, e_req, m_pc); end
         n_tests++; if (instr_valid !== e_valid || irq_ack !== e_ack)
            begin n_fail++; $display("FAIL rand_ctl@%0d: v %b ack %b exp %b %b", cyc, instr_valid, irq_ack, e_valid, e_ack); end
         n_tests++; if (instr !== m_instr || instr_pc !== m_ipc || epc !== m_epc)
            begin n_fail++; $display("FAIL rand_regs@%0d: instr %h pc %h epc %h exp %h %h %h", cyc, instr, instr_pc, epc, m_instr, m_ipc, m_epc); end
         if (rst) begin
            held.delete(); m_pc = 16'h0000; m_pend = 0; m_epc = 0; m_instr = 0; m_ipc = 0;
         end else if (fetching) begin
            if (imem_ack) begin
               if (redir) begin m_pc = tgt; m_pend = 0; end
               else if (m_pend) begin m_pc = m_rpc; m_pend = 0; end
               else begin held.push_back({m_pc, imem_rdata}); m_instr = imem_rdata; m_ipc = m_pc; end
            end else if (redir) begin
               m_rpc = tgt; m_pend = 1;
            end
         end else begin
            if (redir) begin m_pc = tgt; held.delete(); end
            else if (irqt) begin m_epc = held[0][31:16]; m_pc = 16'h0004; held.delete(); end
            else if (!stall) begin m_pc = held[0][31:16] + 16'd1; held.delete(); end
         end
         tick();
      end
      rst = 0; idle();
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_stall();
      test_jmp_br();
      test_fetch_redirect();
      test_irq();
      test_wrap();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
